// File: rtl/seg_display_scanner_if.sv
// Bus between the seven-segment scanner and its host/decoder.
// Holds the load strobe, the value to show, and the per-slot scan outputs.
`timescale 1ns/1ps
interface seg_display_scanner_if #(
  parameter int NUM_DIGITS = 8
) ();
  localparam int IDX_W = $clog2(NUM_DIGITS);

  // Handshake: load is a single-cycle strobe with no ready. value_in is
  // accepted on every rising edge where load is high and rst is low. No
  // back-pressure exists; a later strobe in the same frame replaces an
  // earlier one.
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [3:0]              digit_bin;
  logic                    digit_blank;
  logic [NUM_DIGITS-1:0]   anode;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;
  logic                    pending;

  modport master (
    output value_in, load,
    input  digit_bin, digit_blank, anode, digit_idx, frame_done, pending
  );

  modport slave (
    input  value_in, load,
    output digit_bin, digit_blank, anode, digit_idx, frame_done, pending
  );
endinterface

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with tear-free frame updates.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
`timescale 1ns/1ps
module seg_display_scanner #(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD         = 2,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  seg_display_scanner_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] disp_q, disp_d;
  logic [VAL_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;

  logic slot_end;
  logic frame_wrap;
  logic guard_ok;
  logic blank;
  logic [NUM_DIGITS-1:0] onehot;

  assign slot_end   = (cnt_q == CNT_LAST);
  assign frame_wrap = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // A load on the wrap cycle goes straight to disp; otherwise it waits.
    if (frame_wrap) begin
      if (bus.load) begin
        disp_d = bus.value_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        disp_d = pend_val_q;
        pend_d = 1'b0;
      end
    end else if (bus.load) begin
      pend_val_d = bus.value_in;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (cnt_q >= CNT_W'(GUARD));
    end
  endgenerate

`ifdef SEVSEG_LZ_BLANK_EN
  // Highest non-zero nibble; digit 0 stays lit even when disp is zero.
  logic [IDX_W-1:0] top_nz;
  always_comb begin
    top_nz = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) top_nz = IDX_W'(i);
    end
  end
  assign blank = (idx_q > top_nz);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot[i] = guard_ok && !blank && (idx_q == IDX_W'(i));
    end
  end

  assign bus.anode       = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
  assign bus.digit_bin   = disp_q[{idx_q, 2'b00} +: 4];
  assign bus.digit_blank = blank;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_done  = frame_wrap;
  assign bus.pending     = pend_q;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1.
`timescale 1ns/1ps
module tb_seg_display_scanner;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   pos    = 0;
  logic [15:0] exp_disp = 16'h0000;
  logic        exp_pend = 1'b0;

  seg_display_scanner_if #(.NUM_DIGITS(4)) bus ();

  seg_display_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, pos, obs, exp);
    end
  endtask

  function automatic logic exp_blank(input int idx);
    int top;
    top = 0;
`ifdef SEVSEG_LZ_BLANK_EN
    for (int i = 1; i < 4; i++) begin
      if (exp_disp[4*i +: 4] != 4'h0) top = i;
    end
    return (idx > top);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  // pos counts cycles since reset release: cnt = pos%4, idx = (pos/4)%4
  task automatic check_state(input string tag);
    int cnt;
    int idx;
    logic blk;
    logic [3:0] one;
    logic [3:0] an;
    logic [15:0] sh;
    cnt = pos % 4;
    idx = (pos / 4) % 4;
    blk = exp_blank(idx);
    one = 4'b0001 << idx;
    an  = (cnt >= 1 && !blk) ? ~one : 4'b1111;
    sh  = exp_disp >> (4 * idx);
    chk({tag, ".idx"},   32'(bus.digit_idx),   32'(idx));
    chk({tag, ".bin"},   32'(bus.digit_bin),   32'(sh[3:0]));
    chk({tag, ".anode"}, 32'(bus.anode),       32'(an));
    chk({tag, ".blank"}, 32'(bus.digit_blank), 32'(blk));
    chk({tag, ".fdone"}, 32'(bus.frame_done),  32'(pos % 16 == 15));
    chk({tag, ".pend"},  32'(bus.pending),     32'(exp_pend));
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      tick();
      check_state(tag);
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    bus.value_in = v;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pos = 0;
    chk("reset.anode", 32'(bus.anode), 32'h0000000F);
    chk("reset.bin",   32'(bus.digit_bin), 32'h0);
    check_state("reset");

    // free-running scan, one full frame
    run(16, "idle");

    // mid-frame load is held until the wrap
    strobe(16'hBEEF);
    exp_pend = 1'b1;
    check_state("beef_load");
    run(14, "beef_wait");
    chk("beef_wrap.fdone", 32'(bus.frame_done), 32'h1);
    tick();
    exp_disp = 16'hBEEF;
    exp_pend = 1'b0;
    check_state("beef_show");
    chk("beef.digit0", 32'(bus.digit_bin), 32'hF);

    // two loads in one frame: last wins
    run(1, "beef");
    strobe(16'h1234);
    exp_pend = 1'b1;
    check_state("l1234");
    run(6, "l1234_wait");
    strobe(16'h5678);
    check_state("l5678");
    run(6, "l5678_wait");
    tick();
    exp_disp = 16'h5678;
    exp_pend = 1'b0;
    check_state("show5678");
    chk("l5678.digit0", 32'(bus.digit_bin), 32'h8);
    run(15, "show5678");

    // load on the wrap cycle bypasses pending
    chk("a5a5.fdone_at_load", 32'(bus.frame_done), 32'h1);
    strobe(16'hA5A5);
    exp_disp = 16'hA5A5;
    check_state("a5a5");
    chk("a5a5.digit0", 32'(bus.digit_bin), 32'h5);
    run(2, "a5a5");

    // reset mid-frame drops pending value; load during reset ignored
    strobe(16'h9999);
    exp_pend = 1'b1;
    check_state("p9999");
    run(3, "p9999");
    rst          = 1'b1;
    bus.load     = 1'b1;
    bus.value_in = 16'h1111;
    tick();
    rst      = 1'b0;
    bus.load = 1'b0;
    pos      = 0;
    exp_disp = 16'h0000;
    exp_pend = 1'b0;
    check_state("mid_rst");
    run(16, "after_rst");
    run(15, "after_rst2");

    // leading-zero pattern loaded on the wrap cycle
    strobe(16'h0070);
    exp_disp = 16'h0070;
    check_state("lz0070");
    run(15, "lz0070");
    strobe(16'h0000);
    exp_disp = 16'h0000;
    check_state("lz0000");
    run(16, "lz0000");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a hex value, then scans one digit at a time. For each digit it presents the selected 4-bit nibble to the downstream hex-to-segment decoder and drives the matching anode. New values take effect only at frame boundaries, so the display never tears mid-frame.

## Interface
- `NUM_DIGITS`, 8: digits scanned; `value_in` width is 4*NUM_DIGITS; range 2..8.
- `REFRESH_DIV`, 100000: clock cycles per digit slot; must be at least 2.
- `GUARD`, 2: inactive-anode cycles at the start of each slot (anti-ghosting); range 0..REFRESH_DIV-1.
- `AN_ACTIVE_LOW`, 1: 1 means an active anode is driven 0; 0 means driven 1.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `value_in`, input, 4*NUM_DIGITS: value to display; nibble 0 is the rightmost digit.
- `load`, input, 1: single-cycle strobe; captures `value_in`.
- `digit_bin`, output, 4: nibble of the current digit, feeds the decoder's `binary` input.
- `digit_blank`, output, 1: current digit is blanked.
- `anode`, output, NUM_DIGITS: one-hot digit enable, polarity set by AN_ACTIVE_LOW.
- `digit_idx`, output, $clog2(NUM_DIGITS): current slot index.
- `frame_done`, output, 1: one-cycle pulse on the last cycle of a frame.
- `pending`, output, 1: a loaded value is waiting for the frame boundary.

## Operation
- State registers:
  - `cnt`: 0..REFRESH_DIV-1.
  - `idx`: 0..NUM_DIGITS-1.
  - `disp`: the value being shown.
  - `pend_val` and `pend`.
- All outputs are Moore functions of these registers. There is no combinational path from `value_in` or `load` to any output.
- `cnt` increments every cycle and wraps from REFRESH_DIV-1 to 0. On that wrap, `idx` increments and wraps from NUM_DIGITS-1 to 0.
- `digit_bin` = `disp[4*idx+3 : 4*idx]`.
- Anode enable:
  - `anode[idx]` is active only when `cnt >= GUARD` and `digit_blank == 0`.
  - All other anode bits are inactive.
  - At most one bit is ever active.
- `frame_done` = 1 exactly when `idx == NUM_DIGITS-1` and `cnt == REFRESH_DIV-1`. This is the frame-wrap cycle.
- Load, not on a frame-wrap cycle: `pend_val <= value_in`, `pend <= 1`. If several loads arrive within one frame, the last one wins.
- Frame-wrap edge handling:
  - If `load` is high on the wrap cycle: `disp <= value_in` and `pend <= 0`. `value_in` bypasses `pend_val`.
  - If `load` is low and `pend` is 1: `disp <= pend_val`, `pend <= 0`.
  - Otherwise `disp` holds its value.
- Reset:
  - `cnt`=0, `idx`=0, `disp`=0, `pend_val`=0, `pend`=0.
  - Outputs after reset: `digit_bin`=0, `digit_idx`=0, `frame_done`=0, `pending`=0, `digit_blank`=0.
  - `anode` is all-inactive while `cnt < GUARD`. With GUARD=0, `anode[0]` is active in the cycle right after reset.
- Reset mid-frame discards `disp` and any pending value. `load` is ignored in any cycle where `rst` is high.

## Timing
- A slot lasts REFRESH_DIV cycles. A frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- On a slot change, `digit_bin` and `digit_idx` change on the same edge as `idx`. The anode stays off for GUARD cycles after that edge.
- Load-to-display latency:
  - Minimum: 1 cycle, when loaded on the frame-wrap cycle.
  - Maximum: NUM_DIGITS*REFRESH_DIV cycles.
- `pending` rises the cycle after a non-wrap load and falls the cycle after the frame wrap.
- `frame_done` pulses once per frame and never twice in a row.

## Configuration
- `SEVSEG_LZ_BLANK_EN` defined: leading-zero blanking.
  - `digit_blank` = 1 for every digit index above the most-significant non-zero nibble of `disp`.
  - Digit 0 is never blanked.
  - When `disp` = 0, only digit 0 is lit.
  - Blanked digits keep their anode inactive for the whole slot; `digit_bin` still shows the nibble.
- `SEVSEG_LZ_BLANK_EN` undefined: `digit_blank` is tied to 0 and every digit is lit.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, AN_ACTIVE_LOW=1.
- Reset release, no load -> `anode`=4'b1111 at cnt=0, then 4'b1110 for cnt 1..3. `digit_idx` steps 0,1,2,3,0 every 4 cycles. `frame_done` pulses every 16 cycles.
- Load 16'hBEEF mid-frame -> `pending`=1. `disp` changes only after `frame_done`. `digit_bin` then reads F,E,E,B for idx 0..3.
- Load 16'h1234 and then 16'h5678 in the same frame -> the next frame shows 8,7,6,5. The value 16'h1234 never appears.
- Load 16'hA5A5 on the `frame_done` cycle -> idx 0 of the next frame shows 5. `pending` stays 0.
- With `SEVSEG_LZ_BLANK_EN`, load 16'h0070 -> digits 2 and 3 are blanked with anodes inactive; digits 0 and 1 are lit. For 16'h0000, only digit 0 is lit.
- Assert `rst` mid-frame with `pend`=1 -> the next cycle has `idx`=0, `disp`=0, `pending`=0. The old pending value is never displayed.
